// File: rtl/fifo_sync_flags.sv
// ---------------------------------------------------------------------------
// fifo_sync_flags
//
// Synchronous first-word-fall-through FIFO with occupancy count, full/empty,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow error flags. Storage is a register array with
// synchronous write and combinational read.
//
// Optional feature macro: FIFO_HWM_EN
//   defined   -> high_water tracks peak occupancy since the last reset/flush
//   undefined -> high_water is tied to 0 and no register is built
//
// Parameters
//   DATA_WIDTH  entry width in bits
//   ADDR_WIDTH  pointer width, depth = 1 << ADDR_WIDTH
//   AF_LEVEL    almost_full  when count >= AF_LEVEL (never if AF_LEVEL > depth)
//   AE_LEVEL    almost_empty when count <= AE_LEVEL
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   flush         synchronous queue clear (error flags are kept)
//   err_clr       clears the sticky error flags
//   enQ / deQ     enqueue / dequeue requests
//   data_in       enqueue data
//   data_out      head-of-queue data (fall-through, bypass when empty)
//   empty, full, almost_empty, almost_full   occupancy flags
//   count         occupancy, 0..depth
//   overflow      sticky: an enqueue was rejected
//   underflow     sticky: a dequeue was rejected
//   high_water    peak occupancy
// ---------------------------------------------------------------------------
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic                  enQ,
    input  logic                  deQ,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   high_water
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Thresholds outside 0..depth cannot be represented in the count width,
    // so they are resolved to constant flag values here instead of being
    // truncated into a misleading comparison.
    localparam bit AF_NEVER  = (AF_LEVEL > DEPTH);
    localparam bit AE_ALWAYS = (AE_LEVEL >= DEPTH);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL_C = AF_NEVER  ? '0 : (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL_C = AE_ALWAYS ? '0 : (ADDR_WIDTH+1)'(AE_LEVEL);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;

    // -----------------------------------------------------------------------
    // Flag decode from registered count
    // -----------------------------------------------------------------------
    logic empty_w;
    logic full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);

    assign empty        = empty_w;
    assign full         = full_w;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign almost_full  = AF_NEVER  ? 1'b0 : (count_q >= AF_LVL_C);
    assign almost_empty = AE_ALWAYS ? 1'b1 : (count_q <= AE_LVL_C);

    // -----------------------------------------------------------------------
    // Qualified strobes
    // -----------------------------------------------------------------------
    // A dequeue is honoured only when there is something to pop. An enqueue
    // is honoured when there is room, or when a simultaneous pop frees a slot
    // this edge. On an empty FIFO with both requests the word bypasses the
    // array entirely, so nothing is written.
    logic w_deq;
    logic w_enq;
    logic bypass;
    logic overflow_set;
    logic underflow_set;

    assign w_deq  = deQ & ~empty_w;
    assign w_enq  = enQ & ~(empty_w & deQ) & (~full_w | deQ);
    assign bypass = empty_w & enQ & deQ;

    assign overflow_set  = enQ & full_w  & ~deQ;
    assign underflow_set = deQ & empty_w & ~enQ;

    // -----------------------------------------------------------------------
    // Read port: fall-through head, combinational bypass when empty
    // -----------------------------------------------------------------------
    always_comb begin
        if (bypass) begin
            data_out = data_in;
        end else if (empty_w) begin
            data_out = '0;
        end else begin
            data_out = mem_q[rd_ptr_q];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic (flush and normal operation; reset is applied in the
    // register process and overrides everything here)
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            // Requests on a flush cycle are dropped and raise no error;
            // the sticky flags survive so software can still see them.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_enq) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            unique case ({w_enq, w_deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            // Clear first so a coincident set wins.
            if (err_clr) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (overflow_set) begin
                overflow_d = 1'b1;
            end
            if (underflow_set) begin
                underflow_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    // NOTE: the array has no reset. Occupancy is tracked by the pointers and
    // count, and empty reads return 0 via the read mux, so stale contents are
    // never observable; leaving it unreset lets it map onto plain storage.
    always_ff @(posedge clock) begin
        if (!reset && !flush && w_enq) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // -----------------------------------------------------------------------
    // High-water mark
    // -----------------------------------------------------------------------
`ifdef FIFO_HWM_EN
    logic [ADDR_WIDTH:0] high_water_q, high_water_d;

    always_comb begin
        high_water_d = high_water_q;
        if (flush) begin
            high_water_d = '0;
        end else if (count_d > high_water_q) begin
            high_water_d = count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            high_water_q <= '0;
        end else begin
            high_water_q <= high_water_d;
        end
    end

    assign high_water = high_water_q;
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_flags
//
// Directed self-checking bench for fifo_sync_flags at depth 4 with
// AF_LEVEL=3 and AE_LEVEL=1. Inputs change 1 time unit after a rising edge;
// outputs are sampled after they settle, well away from the next edge.
// Expected high_water values follow whether FIFO_HWM_EN is defined.
// ---------------------------------------------------------------------------
module tb_fifo_sync_flags;

    localparam int DW = 8;
    localparam int AW = 2;

`ifdef FIFO_HWM_EN
    localparam bit HWM = 1'b1;
`else
    localparam bit HWM = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          err_clr;
    logic          enQ;
    logic          deQ;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic [AW:0]   high_water;

    int n_checks = 0;
    int n_pass   = 0;

    // Flag values indexed by occupancy 0..4 (AE_LEVEL=1, AF_LEVEL=3, depth 4).
    int exp_ae   [5] = '{1, 1, 0, 0, 0};
    int exp_af   [5] = '{0, 0, 0, 1, 1};
    int exp_full [5] = '{0, 0, 0, 0, 1};
    int exp_empty[5] = '{1, 0, 0, 0, 0};

    fifo_sync_flags #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (3),
        .AE_LEVEL  (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .err_clr     (err_clr),
        .enQ         (enQ),
        .deQ         (deQ),
        .data_in     (data_in),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .high_water  (high_water)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        data_in = d;
        enQ     = 1'b1;
        tick();
        enQ     = 1'b0;
        #1;
    endtask

    task automatic pop();
        deQ = 1'b1;
        tick();
        deQ = 1'b0;
        #1;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_data_out"}, 32'(data_out), 32'h0);
        check({pfx, "_empty"}, 32'(empty), 32'd1);
        check({pfx, "_full"}, 32'(full), 32'd0);
        check({pfx, "_almost_empty"}, 32'(almost_empty), 32'd1);
        check({pfx, "_almost_full"}, 32'(almost_full), 32'd0);
        check({pfx, "_count"}, 32'(count), 32'd0);
        check({pfx, "_overflow"}, 32'(overflow), 32'd0);
        check({pfx, "_underflow"}, 32'(underflow), 32'd0);
        check({pfx, "_high_water"}, 32'(high_water), 32'd0);
    endtask

    task automatic check_flags(input string pfx, input int occ);
        check({pfx, "_count"}, 32'(count), 32'(occ));
        check({pfx, "_ae"}, 32'(almost_empty), 32'(exp_ae[occ]));
        check({pfx, "_af"}, 32'(almost_full), 32'(exp_af[occ]));
        check({pfx, "_full"}, 32'(full), 32'(exp_full[occ]));
        check({pfx, "_empty"}, 32'(empty), 32'(exp_empty[occ]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_d;

        reset   = 1'b1;
        flush   = 1'b0;
        err_clr = 1'b0;
        enQ     = 1'b0;
        deQ     = 1'b0;
        data_in = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_reset_state("rst");

        // Fill and drain, walking the threshold flags through 0..4.
        check_flags("walk0", 0);
        push(8'h11); check_flags("walk1", 1);
        push(8'h22); check_flags("walk2", 2);
        push(8'h33); check_flags("walk3", 3);
        push(8'h44); check_flags("walk4", 4);

        push(8'h55);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_head", 32'(data_out), 32'h11);
        check("hwm_peak", 32'(high_water), HWM ? 32'd4 : 32'd0);

        check("drain0", 32'(data_out), 32'h11); pop();
        check("drain1", 32'(data_out), 32'h22); pop();
        check("drain2", 32'(data_out), 32'h33); pop();
        check("drain3", 32'(data_out), 32'h44); pop();
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_dout", 32'(data_out), 32'h0);
        check("drain_ae", 32'(almost_empty), 32'd1);

        err_clr = 1'b1; tick(); err_clr = 1'b0; #1;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Wrap-around: 5 rounds of 3 in / 3 out crosses the pointer wrap.
        exp_d = 8'h80;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 3; k++) begin
                push(8'h80 + 8'(3 * r + k));
            end
            for (int k = 0; k < 3; k++) begin
                check("wrap_data", 32'(data_out), 32'(exp_d));
                exp_d = exp_d + 8'd1;
                pop();
            end
        end
        check("wrap_count", 32'(count), 32'd0);

        // Underflow: sticky, set wins over a coincident clear.
        pop();
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        tick();
        check("unf_hold", 32'(underflow), 32'd1);
        err_clr = 1'b1; deQ = 1'b1; tick(); err_clr = 1'b0; deQ = 1'b0; #1;
        check("unf_set_wins", 32'(underflow), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0; #1;
        check("unf_clr", 32'(underflow), 32'd0);

        // Simultaneous enQ/deQ on full.
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        data_in = 8'hE0; enQ = 1'b1; deQ = 1'b1; #1;
        check("fullrw_before", 32'(data_out), 32'hA0);
        tick();
        enQ = 1'b0; deQ = 1'b0; #1;
        check("fullrw_after", 32'(data_out), 32'hA1);
        check("fullrw_count", 32'(count), 32'd4);
        check("fullrw_ovf", 32'(overflow), 32'd0);
        pop(); check("fullrw_d1", 32'(data_out), 32'hA2);
        pop(); check("fullrw_d2", 32'(data_out), 32'hA3);
        pop(); check("fullrw_d3", 32'(data_out), 32'hE0);
        pop(); check("fullrw_empty", 32'(empty), 32'd1);

        // Simultaneous enQ/deQ on empty: combinational bypass.
        data_in = 8'h5A; enQ = 1'b1; deQ = 1'b1; #1;
        check("bypass_dout", 32'(data_out), 32'h5A);
        tick();
        enQ = 1'b0; deQ = 1'b0; #1;
        check("bypass_count", 32'(count), 32'd0);
        check("bypass_unf", 32'(underflow), 32'd0);
        check("bypass_dout_after", 32'(data_out), 32'h0);

        // Flush: errors kept, queue and high_water cleared.
        push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
        check("fl_pre_ovf", 32'(overflow), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0; #1;
        check("fl1_count", 32'(count), 32'd0);
        check("fl1_hwm", 32'(high_water), 32'd0);
        check("fl1_ovf", 32'(overflow), 32'd1);
        push(8'h61); push(8'h62); push(8'h63);
        check("fl_pre_count", 32'(count), 32'd3);
        check("fl_pre_hwm", 32'(high_water), HWM ? 32'd3 : 32'd0);
        flush = 1'b1; enQ = 1'b1; data_in = 8'h64; tick();
        flush = 1'b0; enQ = 1'b0; #1;
        check("fl2_count", 32'(count), 32'd0);
        check("fl2_empty", 32'(empty), 32'd1);
        check("fl2_ovf", 32'(overflow), 32'd1);
        check("fl2_hwm", 32'(high_water), 32'd0);
        check("fl2_dout", 32'(data_out), 32'h0);

        // Reset mid-operation with enQ & deQ active.
        push(8'h71); push(8'h72);
        reset = 1'b1; enQ = 1'b1; deQ = 1'b1; data_in = 8'h73; tick();
        reset = 1'b0; enQ = 1'b0; deQ = 1'b0; #1;
        check_reset_state("midrst");
        push(8'h77);
        check("post_rst_dout", 32'(data_out), 32'h77);
        check("post_rst_count", 32'(count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
